// File: rtl/port_arbiter.sv
// Three-way scratchpad arbiter (IC > MVU > Ctrl with starvation promotion).
// Registers the winning access onto the memory port and tags read returns to their issuer.
module port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 128,
    parameter int LAT    = 2,
    parameter int STARVE = 15
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              reqIC,
    input  logic              reqMVU,
    input  logic              reqCtrl,
    input  logic              weIC,
    input  logic              weMVU,
    input  logic              weCtrl,
    input  logic [ADDR_W-1:0] addrIC,
    input  logic [ADDR_W-1:0] addrMVU,
    input  logic [ADDR_W-1:0] addrCtrl,
    input  logic [DATA_W-1:0] dataIC,
    input  logic [DATA_W-1:0] dataMVU,
    input  logic [DATA_W-1:0] dataCtrl,

    output logic              grntIC,
    output logic              grntMVU,
    output logic              grntCtrl,

    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memData,
    input  logic [DATA_W-1:0] memQ,

    output logic [DATA_W-1:0] rdata,
    output logic              rvldIC,
    output logic              rvldMVU,
    output logic              rvldCtrl
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IC   = 2'd1;
    localparam logic [1:0] OWN_MVU  = 2'd2;
    localparam logic [1:0] OWN_CTRL = 2'd3;
    localparam logic [7:0] STARVE_CNT = 8'(STARVE);

    logic [7:0]        waitMVU_q, waitMVU_d;
    logic [7:0]        waitCtrl_q, waitCtrl_d;
    logic              memEn_q, memEn_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memData_q, memData_d;
    logic [1:0]        tag_q [LAT+1];
    logic [1:0]        tagIn_d;

    logic              anyGrant;
    logic              selWe;
    logic [1:0]        selTag;

    // Starved requesters are promoted ahead of IC; Ctrl wins a simultaneous starvation.
    always_comb begin
        grntIC   = 1'b0;
        grntMVU  = 1'b0;
        grntCtrl = 1'b0;
        if (reqCtrl && (waitCtrl_q == STARVE_CNT)) begin
            grntCtrl = 1'b1;
        end else if (reqMVU && (waitMVU_q == STARVE_CNT)) begin
            grntMVU = 1'b1;
        end else if (reqIC) begin
            grntIC = 1'b1;
        end else if (reqMVU) begin
            grntMVU = 1'b1;
        end else if (reqCtrl) begin
            grntCtrl = 1'b1;
        end
    end

    assign anyGrant = grntIC | grntMVU | grntCtrl;

    always_comb begin
        selWe     = 1'b0;
        selTag    = OWN_NONE;
        memAddr_d = memAddr_q;
        memData_d = memData_q;
        if (grntIC) begin
            selWe     = weIC;
            selTag    = OWN_IC;
            memAddr_d = addrIC;
            memData_d = dataIC;
        end else if (grntMVU) begin
            selWe     = weMVU;
            selTag    = OWN_MVU;
            memAddr_d = addrMVU;
            memData_d = dataMVU;
        end else if (grntCtrl) begin
            selWe     = weCtrl;
            selTag    = OWN_CTRL;
            memAddr_d = addrCtrl;
            memData_d = dataCtrl;
        end
    end

    assign memEn_d = anyGrant;
    assign memWe_d = anyGrant & selWe;
    assign tagIn_d = (anyGrant && !selWe) ? selTag : OWN_NONE;

    // A saturated counter holds at the threshold so the promotion persists until served.
    always_comb begin
        waitMVU_d = 8'd0;
        if (reqMVU && !grntMVU) begin
            waitMVU_d = (waitMVU_q >= STARVE_CNT) ? STARVE_CNT : waitMVU_q + 8'd1;
        end
        waitCtrl_d = 8'd0;
        if (reqCtrl && !grntCtrl) begin
            waitCtrl_d = (waitCtrl_q >= STARVE_CNT) ? STARVE_CNT : waitCtrl_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            waitMVU_q  <= 8'd0;
            waitCtrl_q <= 8'd0;
            memEn_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memData_q  <= '0;
            for (int i = 0; i <= LAT; i++) begin
                tag_q[i] <= OWN_NONE;
            end
        end else begin
            waitMVU_q  <= waitMVU_d;
            waitCtrl_q <= waitCtrl_d;
            memEn_q    <= memEn_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memData_q  <= memData_d;
            tag_q[0]   <= tagIn_d;
            for (int i = 1; i <= LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign memEn   = memEn_q;
    assign memWe   = memWe_q;
    assign memAddr = memAddr_q;
    assign memData = memData_q;

    // Stage LAT lines up with memQ for a read issued LAT+1 cycles after its grant.
    assign rdata    = memQ;
    assign rvldIC   = (tag_q[LAT] == OWN_IC);
    assign rvldMVU  = (tag_q[LAT] == OWN_MVU);
    assign rvldCtrl = (tag_q[LAT] == OWN_CTRL);

endmodule

// File: tb/tb_port_arbiter.sv
// Testbench for port_arbiter: directed vectors, an emulated memory macro and a
// per-cycle reference model of arbitration, aging and read-return tagging.
module tb_port_arbiter;

    localparam int AW     = 9;
    localparam int DW     = 128;
    localparam int LAT    = 2;
    localparam int STARVE = 15;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          reqIC = 1'b0, reqMVU = 1'b0, reqCtrl = 1'b0;
    logic          weIC = 1'b0, weMVU = 1'b0, weCtrl = 1'b0;
    logic [AW-1:0] addrIC = '0, addrMVU = '0, addrCtrl = '0;
    logic [DW-1:0] dataIC = '0, dataMVU = '0, dataCtrl = '0;
    logic          grntIC, grntMVU, grntCtrl;
    logic          memEn, memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memData, memQ, rdata;
    logic          rvldIC, rvldMVU, rvldCtrl;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT), .STARVE(STARVE)) dut (
        .clk(clk), .rstn(rstn),
        .reqIC(reqIC), .reqMVU(reqMVU), .reqCtrl(reqCtrl),
        .weIC(weIC), .weMVU(weMVU), .weCtrl(weCtrl),
        .addrIC(addrIC), .addrMVU(addrMVU), .addrCtrl(addrCtrl),
        .dataIC(dataIC), .dataMVU(dataMVU), .dataCtrl(dataCtrl),
        .grntIC(grntIC), .grntMVU(grntMVU), .grntCtrl(grntCtrl),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memData(memData),
        .memQ(memQ), .rdata(rdata),
        .rvldIC(rvldIC), .rvldMVU(rvldMVU), .rvldCtrl(rvldCtrl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Emulated single-port memory macro with LAT cycles of read latency.
    logic [DW-1:0] sram [512];
    logic [DW-1:0] memStage [LAT];

    initial begin
        for (int i = 0; i < 512; i++) sram[i] = {16{8'(i)}};
        for (int i = 0; i < LAT; i++) memStage[i] = '0;
    end

    always @(posedge clk) begin
        if (memEn && memWe) sram[memAddr] <= memData;
        memStage[0] <= (memEn && !memWe) ? sram[memAddr] : {4{32'(cyc) ^ 32'hC0DE0000}};
        for (int i = 1; i < LAT; i++) memStage[i] <= memStage[i-1];
    end

    assign memQ = memStage[LAT-1];

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: priority rules, wait counters, memory contents and expected returns.
    int            mWaitMVU = 0, mWaitCtrl = 0;
    logic          eEn = 1'b0, eWe = 1'b0;
    logic [AW-1:0] eAddr = '0;
    logic [DW-1:0] eData = '0;
    logic [DW-1:0] modelMem [512];
    int            pendOwner [int];
    logic [DW-1:0] pendData [int];

    initial for (int i = 0; i < 512; i++) modelMem[i] = {16{8'(i)}};

    function automatic int pickWinner(input bit rI, input bit rM, input bit rC, input int wM, input int wC);
        if (rC && wC == STARVE) return 3;
        if (rM && wM == STARVE) return 2;
        if (rI) return 1;
        if (rM) return 2;
        if (rC) return 3;
        return 0;
    endfunction

    always @(negedge clk) begin
        int g;
        int own;
        if (!rstn) begin
            mWaitMVU = 0; mWaitCtrl = 0;
            eEn = 1'b0; eWe = 1'b0; eAddr = '0; eData = '0;
            pendOwner.delete();
            pendData.delete();
        end
        g = pickWinner(reqIC, reqMVU, reqCtrl, mWaitMVU, mWaitCtrl);
        checkOutput("model grntIC", grntIC, (g == 1));
        checkOutput("model grntMVU", grntMVU, (g == 2));
        checkOutput("model grntCtrl", grntCtrl, (g == 3));
        checkOutput("model memEn", memEn, eEn);
        checkOutput("model memWe", memWe, eWe);
        checkOutput("model memAddr", memAddr, eAddr);
        checkOutput("model memData", memData, eData);
        own = pendOwner.exists(cyc) ? pendOwner[cyc] : 0;
        checkOutput("model rvldIC", rvldIC, (own == 1));
        checkOutput("model rvldMVU", rvldMVU, (own == 2));
        checkOutput("model rvldCtrl", rvldCtrl, (own == 3));
        if (own != 0) checkOutput("model rdata", rdata, pendData[cyc]);
        checkOutput("model rdata passthru", rdata, memQ);
        if (rstn) begin
            mWaitMVU  = (reqMVU && g != 2) ? ((mWaitMVU < STARVE) ? mWaitMVU + 1 : STARVE) : 0;
            mWaitCtrl = (reqCtrl && g != 3) ? ((mWaitCtrl < STARVE) ? mWaitCtrl + 1 : STARVE) : 0;
            eEn = (g != 0);
            eWe = 1'b0;
            if (g != 0) begin
                logic          w;
                logic [AW-1:0] a;
                logic [DW-1:0] d;
                w = (g == 1) ? weIC : (g == 2) ? weMVU : weCtrl;
                a = (g == 1) ? addrIC : (g == 2) ? addrMVU : addrCtrl;
                d = (g == 1) ? dataIC : (g == 2) ? dataMVU : dataCtrl;
                eWe = w; eAddr = a; eData = d;
                if (w) begin
                    modelMem[a] = d;
                end else begin
                    pendOwner[cyc + 1 + LAT] = g;
                    pendData[cyc + 1 + LAT]  = modelMem[a];
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input bit req, input bit we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data);
        case (port)
            1: begin reqIC = req; weIC = we; addrIC = addr; dataIC = data; end
            2: begin reqMVU = req; weMVU = we; addrMVU = addr; dataMVU = data; end
            default: begin reqCtrl = req; weCtrl = we; addrCtrl = addr; dataCtrl = data; end
        endcase
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, tests %0d, failed %0d", tests, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("reset memEn", memEn, 0);
        checkOutput("reset memAddr", memAddr, 0);
        checkOutput("reset rvldIC", rvldIC, 0);
        nextCycle();

        // Single MVU read granted in the first cycle out of reset.
        rstn = 1'b1;
        applyStimulus(2, 1, 0, 9'h05, '0);
        @(negedge clk);
        checkOutput("t1 grntMVU", grntMVU, 1);
        checkOutput("t1 grntIC", grntIC, 0);
        nextCycle();
        applyStimulus(2, 0, 0, 9'h05, '0);
        @(negedge clk);
        checkOutput("t1 memEn", memEn, 1);
        checkOutput("t1 memAddr", memAddr, 9'h05);
        checkOutput("t1 memWe", memWe, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 early rvldMVU", rvldMVU, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1 rvldMVU", rvldMVU, 1);
        checkOutput("t1 rdata", rdata, 128'h05050505_05050505_05050505_05050505);
        checkOutput("t1 rvldIC", rvldIC, 0);
        checkOutput("t1 rvldCtrl", rvldCtrl, 0);
        nextCycle();

        // Fixed priority with all three requesting and counters idle.
        applyStimulus(1, 1, 0, 9'h21, '0);
        applyStimulus(2, 1, 0, 9'h22, '0);
        applyStimulus(3, 1, 0, 9'h23, '0);
        @(negedge clk);
        checkOutput("t2 grntIC", grntIC, 1);
        checkOutput("t2 grntMVU", grntMVU, 0);
        checkOutput("t2 grntCtrl", grntCtrl, 0);
        nextCycle();
        applyStimulus(1, 0, 0, 9'h21, '0);
        @(negedge clk);
        checkOutput("t2 memAddr", memAddr, 9'h21);
        checkOutput("t2 grntMVU next", grntMVU, 1);
        nextCycle();
        applyStimulus(2, 0, 0, 9'h22, '0);
        @(negedge clk);
        checkOutput("t2 grntCtrl last", grntCtrl, 1);
        nextCycle();
        applyStimulus(3, 0, 0, 9'h23, '0);
        repeat (4) nextCycle();

        // MVU starvation under a continuous IC stream.
        applyStimulus(1, 1, 0, 9'h30, '0);
        applyStimulus(2, 1, 0, 9'h31, '0);
        for (int k = 0; k < STARVE; k++) begin
            @(negedge clk);
            checkOutput("t3 grntIC waiting", grntIC, 1);
            checkOutput("t3 grntMVU waiting", grntMVU, 0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t3 grntMVU starved", grntMVU, 1);
        checkOutput("t3 grntIC starved", grntIC, 0);
        nextCycle();
        applyStimulus(2, 0, 0, 9'h31, '0);
        @(negedge clk);
        checkOutput("t3 grntIC resumes", grntIC, 1);
        nextCycle();

        // Simultaneous MVU and Ctrl starvation: Ctrl, then MVU, then IC.
        applyStimulus(2, 1, 0, 9'h32, '0);
        applyStimulus(3, 1, 0, 9'h33, '0);
        for (int k = 0; k < STARVE; k++) begin
            @(negedge clk);
            checkOutput("t4 grntIC waiting", grntIC, 1);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t4 grntCtrl starved", grntCtrl, 1);
        checkOutput("t4 grntMVU held", grntMVU, 0);
        nextCycle();
        applyStimulus(3, 0, 0, 9'h33, '0);
        @(negedge clk);
        checkOutput("t4 grntMVU starved", grntMVU, 1);
        checkOutput("t4 grntIC blocked", grntIC, 0);
        nextCycle();
        applyStimulus(2, 0, 0, 9'h32, '0);
        @(negedge clk);
        checkOutput("t4 grntIC resumes", grntIC, 1);
        nextCycle();
        applyStimulus(1, 0, 0, 9'h30, '0);
        repeat (5) nextCycle();

        // Alternating IC writes and Ctrl reads of the same address.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(1, 1, 1, 9'h10, {16{8'hAA}} ^ DW'(i));
                applyStimulus(3, 0, 0, 9'h10, '0);
            end else begin
                applyStimulus(1, 0, 0, 9'h10, '0);
                applyStimulus(3, 1, 0, 9'h10, '0);
            end
            @(negedge clk);
            if (i > 0) checkOutput("t5 memWe pattern", memWe, ((i - 1) % 2 == 0));
            if (i >= 4) checkOutput("t5 rvldCtrl pattern", rvldCtrl, (i % 2 == 0));
            if (i >= 4 && i % 2 == 0) checkOutput("t5 rdata", rdata, {16{8'hAA}} ^ DW'(i - 4));
            if (i >= 4 && i % 2 == 0) checkOutput("t5 rvldIC write", rvldIC, 0);
            nextCycle();
        end
        applyStimulus(1, 0, 0, 9'h10, '0);
        applyStimulus(3, 0, 0, 9'h10, '0);
        repeat (5) nextCycle();

        // Reset while an IC read is in flight.
        applyStimulus(1, 1, 0, 9'h40, '0);
        @(negedge clk);
        checkOutput("t6 grntIC", grntIC, 1);
        nextCycle();
        applyStimulus(1, 0, 0, 9'h40, '0);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("t6 memEn in reset", memEn, 0);
        checkOutput("t6 memAddr in reset", memAddr, 0);
        nextCycle();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t6 no rvldIC", rvldIC, 0);
            nextCycle();
        end
        applyStimulus(2, 1, 0, 9'h07, '0);
        @(negedge clk);
        checkOutput("t6 grntMVU after reset", grntMVU, 1);
        nextCycle();
        applyStimulus(2, 0, 0, 9'h07, '0);
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("t6 rvldMVU", rvldMVU, 1);
        checkOutput("t6 rdata", rdata, 128'h07070707_07070707_07070707_07070707);
        repeat (3) nextCycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Clocked arbiter sharing one single-port scratchpad memory among three requesters: instruction fetch (IC), matrix-vector unit (MVU) and control (Ctrl). Each cycle it grants at most one requester by fixed priority IC > MVU > Ctrl, with an aging rule that forcibly promotes a starved MVU or Ctrl request. It registers the winning access onto the memory port and routes read data back, tagged to the requester that issued it. It sits between the three requester ports and the memory macro.

## Interface
- a, 9, address width
- w, 128, data width
- l, 2, memory read latency in cycles from registered memEn to valid memQ (legal 1..4)
- s, 15, starvation threshold in cycles (legal 1..255)

- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- reqIC / reqMVU / reqCtrl  in  1  access request; held until granted
- weIC / weMVU / weCtrl  in  1  1 = write, 0 = read; valid while req is high
- addrIC / addrMVU / addrCtrl  in  a  access address
- dataIC / dataMVU / dataCtrl  in  w  write data
- grntIC / grntMVU / grntCtrl  out  1  combinational grant; request accepted this cycle
- memEn  out  1  registered memory enable
- memWe  out  1  registered write enable
- memAddr  out  a  registered address
- memData  out  w  registered write data
- memQ  in  w  memory read data
- rdata  out  w  read data, combinational pass-through of memQ
- rvldIC / rvldMVU / rvldCtrl  out  1  rdata holds the read result for that requester

## Operation
- Wait counters waitMVU and waitCtrl are 8 bits wide.
  - Each increments, saturating at s, on every cycle its req is high and its grnt is low.
  - Each clears to 0 on a grant, or on any cycle its req is low.
- Grant priority, evaluated from current reqs and registered counters, first match wins:
  1. reqCtrl and waitCtrl == s -> Ctrl
  2. reqMVU and waitMVU == s -> MVU
  3. reqIC -> IC
  4. reqMVU -> MVU
  5. reqCtrl -> Ctrl
- At most one grnt is high in any cycle. With no req, no grant.
- On a grant, the next edge loads memEn = 1, memWe = the requester's we, memAddr = its addr and memData = its data.
- With no grant, memEn and memWe load 0. memAddr and memData hold their previous values.
- Owner tag pipeline:
  - A 2-bit tag shift register of depth l+1 records the owner of each granted read: 0 none, 1 IC, 2 MVU, 3 Ctrl. Writes enter tag 0.
  - rvldX is high exactly when the tag at the pipeline output equals X.
- The requester changes addr, data and we only in the cycle after its grant, or while not requesting.
- No backpressure on read return. Requesters must accept rdata when rvld is high.

## Timing
- Grant in cycle T -> memEn, memWe, memAddr, memData valid in T+1 -> for a read, rvldX high and rdata = memQ in cycle T+1+l, for exactly one cycle.
- Throughput: one access per cycle. Back-to-back grants to the same or different requesters are allowed.
- Reset (rstn low, async):
  - memEn, memWe, memAddr, memData, all rvld, both counters and all tags go to 0 immediately.
  - grnt outputs remain purely combinational from req and counters.
- Reset mid-operation: in-flight reads are discarded. No rvld is asserted for them after rstn rises.
- The first grant is possible in the first cycle with rstn high.
- Simultaneous starvation of MVU and Ctrl:
  - Ctrl wins. MVU's counter stays at s, so MVU wins the next cycle, ahead of IC.
- A saturated counter stays at s while its requester waits.
- l = 1 is the minimum. The tag pipeline must never alias two reads into one rvld cycle.

## Test plan
- Reset then single read: reqMVU=1, addrMVU=0x05, weMVU=0 at T -> grntMVU=1 at T; memEn=1, memAddr=0x05, memWe=0 at T+1; rvldMVU=1, rdata=memQ at T+3 (l=2); all other rvld 0.
- Priority: reqIC, reqMVU and reqCtrl all high in one cycle, counters 0 -> only grntIC=1; memAddr=addrIC next cycle.
- Starvation (s=15): reqIC held high continuously, reqMVU high from T0 -> grntMVU=1 in cycle T0+15, grntIC=0 that cycle; waitMVU=0 after.
- Dual starvation: IC always requesting, MVU and Ctrl requesting from the same cycle T0 -> grntCtrl at T0+15, grntMVU at T0+16, IC resumes at T0+17.
- Mixed stream: alternating IC write (0x10, data 0xAA..) and Ctrl read (0x10) every cycle -> memWe pattern 1,0,1,0; rvldCtrl pulses every other cycle, l+1 cycles after each Ctrl grant; no rvld for writes.
- Reset mid-read: grant an IC read, pull rstn low at T+1 for one cycle -> memEn=0 immediately; no rvldIC ever; the next request after release is served normally.
